// File: rtl/mem_access_ctrl_pkg.sv
// Shared CPU definitions: access size codes, memory FSM encoding and alignment/replication helpers.
package mem_access_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_DONE = 2'b11
  } mac_state_e;

  // Size code 11 falls into the word rule
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = addr[0];
      default: is_misaligned = |addr;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] replicate_wdata(input logic [1:0] size,
                                                       input logic [XLEN-1:0] wd);
    case (size)
      SZ_BYTE: replicate_wdata = {4{wd[7:0]}};
      SZ_HALF: replicate_wdata = {2{wd[15:0]}};
      default: replicate_wdata = wd;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// SRAM-like data bus between the memory access controller (master) and memory (slave).
interface mem_access_ctrl_if;

  logic                                  data_req;
  logic                                  data_wr;
  logic [1:0]                            data_size;
  logic [mem_access_ctrl_pkg::XLEN-1:0]  data_addr;
  logic [mem_access_ctrl_pkg::XLEN-1:0]  data_wdata;
  logic                                  data_addr_ok;
  logic                                  data_data_ok;
  logic [mem_access_ctrl_pkg::XLEN-1:0]  data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );

endinterface

// File: rtl/mem_access_ctrl_load_align.sv
// Load alignment: picks the addressed byte/half of the read word (little-endian) and extends it.
module load_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr,
  input  logic [1:0]      size,
  input  logic            sign,
  output logic [XLEN-1:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (addr)
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      2'd3:    w_byte = rdata[31:24];
      default: w_byte = rdata[7:0];
    endcase
    w_half = addr[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: data = {{24{sign & w_byte[7]}}, w_byte};
      SZ_HALF: data = {{16{sign & w_half[15]}}, w_half};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// M-stage memory access controller: turns load/store controls into one-outstanding
// SRAM-like bus transactions, generates the pipeline stall and aligned load data.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            memtoregM,
  input  logic            memwriteM,
  input  logic [1:0]      memsizeM,
  input  logic            loadsignM,
  input  logic [XLEN-1:0] aluoutM,
  input  logic [XLEN-1:0] writedataM,
  input  logic            flushM,
  input  logic            ext_stall,
  output logic            mem_stallM,
  output logic [XLEN-1:0] readdataM,
  output logic            adelM,
  output logic            adesM,
  mem_access_ctrl_if.master bus
);

  mac_state_e      r_state, w_state_nxt;
  logic            r_flushed;
  logic            r_cmpl_pend;
  logic [XLEN-1:0] r_hold;
  logic [XLEN-1:0] w_load;
  logic            w_misaligned, w_access, w_flush_now;
  logic            w_req, w_stall, w_cmpl, w_capture;

  assign w_misaligned = is_misaligned(memsizeM, aluoutM[1:0]);
  assign w_access     = (memtoregM | memwriteM) & ~flushM & ~w_misaligned;
  assign w_flush_now  = r_flushed | (flushM & ((r_state == ST_ADDR) | (r_state == ST_DATA)));
  assign w_capture    = w_cmpl & ~w_flush_now;

  load_align u_load_align (
    .rdata (bus.data_rdata),
    .addr  (aluoutM[1:0]),
    .size  (memsizeM),
    .sign  (loadsignM),
    .data  (w_load)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // r_cmpl_pend: a flushed completion under ext_stall whose M slot has not advanced yet
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_stall     = 1'b0;
    w_cmpl      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_stall = w_access;
        if (w_access && !r_cmpl_pend) begin
          w_req       = 1'b1;
          w_state_nxt = bus.data_addr_ok ? ST_DATA : ST_ADDR;
        end
      end
      ST_ADDR: begin
        w_req   = 1'b1;
        w_stall = 1'b1;
        if (bus.data_addr_ok) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (bus.data_data_ok) begin
          w_cmpl      = 1'b1;
          w_state_nxt = (ext_stall && !w_flush_now) ? ST_DONE : ST_IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      ST_DONE: begin
        if (!ext_stall) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flushed   <= 1'b0;
      r_cmpl_pend <= 1'b0;
      r_hold      <= '0;
    end else begin
      r_flushed <= ((w_state_nxt == ST_ADDR) || (w_state_nxt == ST_DATA)) ? w_flush_now : 1'b0;
      if (w_cmpl)          r_cmpl_pend <= w_flush_now & ext_stall;
      else if (!ext_stall) r_cmpl_pend <= 1'b0;
      if (w_capture)       r_hold <= w_load;
    end
  end

  // Address and write data pass through even in reset; everything else is forced low
  assign bus.data_req   = w_req & ~rst;
  assign bus.data_wr    = memwriteM & ~rst;
  assign bus.data_size  = rst ? 2'b00 : memsizeM;
  assign bus.data_addr  = aluoutM;
  assign bus.data_wdata = replicate_wdata(memsizeM, writedataM);

  assign mem_stallM = w_stall & ~rst;
  assign adelM      = memtoregM & w_misaligned & ~rst;
  assign adesM      = memwriteM & w_misaligned & ~rst;
  assign readdataM  = rst ? '0 : (w_capture ? w_load : r_hold);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a load-result scoreboard.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        memtoregM, memwriteM, loadsignM, flushM, ext_stall;
  logic [1:0]  memsizeM;
  logic [31:0] aluoutM, writedataM, readdataM;
  logic        mem_stallM, adelM, adesM;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  typedef struct packed {
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t ld_tab [7] = '{
    '{2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF},
    '{2'b00, 1'b1, 32'h0000_0103, 32'h8012_3456, 32'hFFFF_FF80},
    '{2'b00, 1'b0, 32'h0000_0103, 32'h8012_3456, 32'h0000_0080},
    '{2'b01, 1'b1, 32'h0000_0102, 32'h8001_7F00, 32'hFFFF_8001},
    '{2'b01, 1'b0, 32'h0000_0100, 32'h1234_F00D, 32'h0000_F00D},
    '{2'b00, 1'b1, 32'h0000_0101, 32'h0000_7F00, 32'h0000_007F},
    '{2'b11, 1'b0, 32'h0000_0104, 32'hCAFE_F00D, 32'hCAFE_F00D}
  };

  mem_access_ctrl_if bus_if ();

  mem_access_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .memtoregM  (memtoregM),
    .memwriteM  (memwriteM),
    .memsizeM   (memsizeM),
    .loadsignM  (loadsignM),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .flushM     (flushM),
    .ext_stall  (ext_stall),
    .mem_stallM (mem_stallM),
    .readdataM  (readdataM),
    .adelM      (adelM),
    .adesM      (adesM),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic ld, input logic st, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
    memtoregM  = ld;
    memwriteM  = st;
    memsizeM   = sz;
    loadsignM  = sg;
    aluoutM    = a;
    writedataM = wd;
  endtask

  task automatic bus_in(input logic aok, input logic dok, input logic [31:0] rd);
    bus_if.data_addr_ok = aok;
    bus_if.data_data_ok = dok;
    bus_if.data_rdata   = rd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk_ctl(input string tag, input logic req, input logic stall);
    chk({tag, "_req"},   32'(bus_if.data_req), 32'(req));
    chk({tag, "_stall"}, 32'(mem_stallM),      32'(stall));
  endtask

  initial begin
    rst = 1'b1;
    flushM = 1'b0;
    ext_stall = 1'b0;
    set_op(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0100, 32'hA5A5_0F0F);
    bus_in(1'b0, 1'b0, 32'h0);

    // Reset: outputs low, address/wdata track inputs
    next_cycle();
    mid();
    chk_ctl("rst", 1'b0, 1'b0);
    chk("rst_rd",    readdataM, 32'h0);
    chk("rst_size",  32'(bus_if.data_size), 32'h0);
    chk("rst_wr",    32'(bus_if.data_wr), 32'h0);
    chk("rst_addr",  bus_if.data_addr, 32'h0000_0100);
    chk("rst_wdata", bus_if.data_wdata, 32'hA5A5_0F0F);
    chk("rst_state", 32'(dut.r_state), 32'(ST_IDLE));

    next_cycle();
    rst = 1'b0;
    set_op(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    mid();
    chk_ctl("idle", 1'b0, 1'b0);

    // Back-to-back loads, addr_ok at issue, data_ok next cycle
    for (int i = 0; i < 7; i++) begin
      next_cycle();
      set_op(1'b1, 1'b0, ld_tab[i].sz, ld_tab[i].sg, ld_tab[i].addr, 32'h0);
      bus_in(1'b1, 1'b0, 32'h0);
      exp_q.push_back(ld_tab[i].exp);
      mid();
      chk_ctl($sformatf("ld%0d_iss", i), 1'b1, 1'b1);
      chk($sformatf("ld%0d_size", i), 32'(bus_if.data_size), 32'(ld_tab[i].sz));
      next_cycle();
      bus_in(1'b0, 1'b1, ld_tab[i].rdata);
      mid();
      chk_ctl($sformatf("ld%0d_cmp", i), 1'b0, 1'b0);
      chk($sformatf("ld%0d_data", i), readdataM, exp_q.pop_front());
    end

    // Stray data_ok in IDLE is ignored
    next_cycle();
    set_op(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    bus_in(1'b0, 1'b1, 32'h0BAD_0BAD);
    mid();
    chk("stray_rd", readdataM, 32'hCAFE_F00D);
    chk_ctl("stray", 1'b0, 1'b0);
    chk("stray_state", 32'(dut.r_state), 32'(ST_IDLE));

    // Half store, addr_ok delayed three cycles: four stable request cycles
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      if (i == 0) set_op(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h0000_0202, 32'h1234_ABCD);
      bus_in(i == 3, 1'b0, 32'h0);
      mid();
      chk_ctl($sformatf("sth%0d", i), 1'b1, 1'b1);
      chk($sformatf("sth%0d_wr", i),    32'(bus_if.data_wr), 32'h1);
      chk($sformatf("sth%0d_size", i),  32'(bus_if.data_size), 32'h1);
      chk($sformatf("sth%0d_addr", i),  bus_if.data_addr, 32'h0000_0202);
      chk($sformatf("sth%0d_wdata", i), bus_if.data_wdata, 32'hABCD_ABCD);
    end
    next_cycle();
    bus_in(1'b0, 1'b1, 32'h0);
    mid();
    chk_ctl("sth_cmp", 1'b0, 1'b0);

    // Byte store replication
    next_cycle();
    set_op(1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h0000_0205, 32'h0000_00EF);
    bus_in(1'b1, 1'b0, 32'h0);
    mid();
    chk_ctl("stb_iss", 1'b1, 1'b1);
    chk("stb_wdata", bus_if.data_wdata, 32'hEFEF_EFEF);
    next_cycle();
    bus_in(1'b0, 1'b1, 32'h0);
    mid();
    chk_ctl("stb_cmp", 1'b0, 1'b0);

    // Misaligned accesses: exception flags, no request, no stall
    next_cycle();
    set_op(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0101, 32'h0);
    bus_in(1'b0, 1'b0, 32'h0);
    mid();
    chk("mislw_adel", 32'(adelM), 32'h1);
    chk("mislw_ades", 32'(adesM), 32'h0);
    chk_ctl("mislw", 1'b0, 1'b0);
    next_cycle();
    mid();
    chk_ctl("mislw2", 1'b0, 1'b0);
    chk("mislw2_state", 32'(dut.r_state), 32'(ST_IDLE));
    next_cycle();
    set_op(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h0000_0102, 32'h1111_2222);
    mid();
    chk("missw_ades", 32'(adesM), 32'h1);
    chk("missw_adel", 32'(adelM), 32'h0);
    chk_ctl("missw", 1'b0, 1'b0);
    next_cycle();
    set_op(1'b1, 1'b0, SZ_HALF, 1'b1, 32'h0000_0103, 32'h0);
    mid();
    chk("mislh_adel", 32'(adelM), 32'h1);
    chk_ctl("mislh", 1'b0, 1'b0);

    // Completion under ext_stall: DONE holds the result, then a fresh issue
    next_cycle();
    set_op(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0300, 32'h0);
    bus_in(1'b1, 1'b0, 32'h0);
    exp_q.push_back(32'h1122_3344);
    mid();
    chk_ctl("es_iss", 1'b1, 1'b1);
    next_cycle();
    bus_in(1'b0, 1'b1, 32'h1122_3344);
    ext_stall = 1'b1;
    mid();
    chk_ctl("es_cmp", 1'b0, 1'b0);
    chk("es_cmp_rd", readdataM, exp_q.pop_front());
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      bus_in(1'b0, 1'b0, 32'h7777_7777);
      mid();
      chk($sformatf("es_done%0d_state", k), 32'(dut.r_state), 32'(ST_DONE));
      chk_ctl($sformatf("es_done%0d", k), 1'b0, 1'b0);
      chk($sformatf("es_done%0d_rd", k), readdataM, 32'h1122_3344);
    end
    next_cycle();
    ext_stall = 1'b0;
    mid();
    chk("es_rel_state", 32'(dut.r_state), 32'(ST_DONE));
    chk_ctl("es_rel", 1'b0, 1'b0);
    chk("es_rel_rd", readdataM, 32'h1122_3344);
    next_cycle();
    set_op(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0304, 32'h0);
    bus_in(1'b1, 1'b0, 32'h0);
    exp_q.push_back(32'h5566_7788);
    mid();
    chk("b2b_state", 32'(dut.r_state), 32'(ST_IDLE));
    chk_ctl("b2b_iss", 1'b1, 1'b1);
    next_cycle();
    bus_in(1'b0, 1'b1, 32'h5566_7788);
    mid();
    chk("b2b_rd", readdataM, exp_q.pop_front());

    // Flush during DATA: completes, result dropped, no DONE
    next_cycle();
    set_op(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0400, 32'h0);
    bus_in(1'b1, 1'b0, 32'h0);
    mid();
    chk_ctl("fd_iss", 1'b1, 1'b1);
    next_cycle();
    bus_in(1'b0, 1'b0, 32'h0);
    flushM = 1'b1;
    mid();
    chk_ctl("fd_wait", 1'b0, 1'b1);
    next_cycle();
    bus_in(1'b0, 1'b1, 32'h9999_9999);
    mid();
    chk_ctl("fd_cmp", 1'b0, 1'b0);
    chk("fd_cmp_rd", readdataM, 32'h5566_7788);
    next_cycle();
    flushM = 1'b0;
    set_op(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    bus_in(1'b0, 1'b0, 32'h0);
    mid();
    chk("fd_post_state", 32'(dut.r_state), 32'(ST_IDLE));
    chk("fd_post_rd", readdataM, 32'h5566_7788);

    // Flush during ADDR: request stays up, flag survives flushM dropping
    next_cycle();
    set_op(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0500, 32'h0);
    bus_in(1'b0, 1'b0, 32'h0);
    mid();
    chk_ctl("fa_iss", 1'b1, 1'b1);
    next_cycle();
    flushM = 1'b1;
    mid();
    chk_ctl("fa_flush", 1'b1, 1'b1);
    next_cycle();
    flushM = 1'b0;
    bus_in(1'b1, 1'b0, 32'h0);
    mid();
    chk_ctl("fa_aok", 1'b1, 1'b1);
    chk("fa_addr", bus_if.data_addr, 32'h0000_0500);
    next_cycle();
    bus_in(1'b0, 1'b1, 32'h1212_1212);
    mid();
    chk_ctl("fa_cmp", 1'b0, 1'b0);
    chk("fa_cmp_rd", readdataM, 32'h5566_7788);
    next_cycle();
    set_op(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    bus_in(1'b0, 1'b0, 32'h0);
    mid();
    chk("fa_post_state", 32'(dut.r_state), 32'(ST_IDLE));

    // Reset mid-transaction, then a late data_ok is ignored
    next_cycle();
    set_op(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0600, 32'h0);
    bus_in(1'b1, 1'b0, 32'h0);
    mid();
    chk_ctl("mr_iss", 1'b1, 1'b1);
    next_cycle();
    bus_in(1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    mid();
    chk_ctl("mr_rst", 1'b0, 1'b0);
    chk("mr_rst_rd", readdataM, 32'h0);
    chk("mr_rst_addr", bus_if.data_addr, 32'h0000_0600);
    chk("mr_rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    next_cycle();
    rst = 1'b0;
    set_op(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    bus_in(1'b0, 1'b1, 32'h3434_3434);
    mid();
    chk("mr_late_rd", readdataM, 32'h0);
    chk("mr_late_state", 32'(dut.r_state), 32'(ST_IDLE));
    next_cycle();
    bus_in(1'b0, 1'b0, 32'h0);

    chk("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have ports clk (in, 1, the single clock) and rst (in, 1); reset is asynchronous and active-high.
REQ-002 SHALL have memtoregM (in, 1), the load-in-M control from the pipeline controller.
REQ-003 SHALL have memwriteM (in, 1), the store-in-M control.
REQ-004 SHALL have memsizeM (in, 2): 00 byte, 01 half, 10 word; 11 is treated as word.
REQ-005 SHALL have loadsignM (in, 1): 1 sign-extends sub-word loads, 0 zero-extends.
REQ-006 SHALL have aluoutM (in, 32), the effective address, and writedataM (in, 32), the store data.
REQ-007 SHALL have flushM (in, 1), which kills the M instruction, and ext_stall (in, 1), the stall from sources other than this block.
REQ-008 SHALL have the sram-like bus outputs data_req (1), data_wr (1), data_size (2), data_addr (32) and data_wdata (32).
REQ-009 SHALL have the bus inputs data_addr_ok (1), data_data_ok (1) and data_rdata (32).
REQ-010 SHALL have the outputs mem_stallM (1), readdataM (32), adelM (1) and adesM (1).

Function
REQ-011 SHALL define access = (memtoregM | memwriteM) & ~flushM & ~misaligned.
- misaligned: half with addr[0]=1, or word with addr[1:0]≠00.
REQ-012 SHALL drive adelM = memtoregM & misaligned and adesM = memwriteM & misaligned, combinationally; a misaligned access issues no bus request and raises no stall.
REQ-013 SHALL implement the FSM states IDLE, ADDR, DATA and DONE.
REQ-014 In IDLE, SHALL assert data_req combinationally when access=1 and the last completion has been consumed.
- If data_addr_ok=1 in the same cycle, go to DATA; otherwise go to ADDR.
REQ-015 In ADDR, SHALL hold data_req=1 with data_wr, data_size, data_addr and data_wdata unchanged until data_addr_ok=1, then go to DATA.
- flushM does not withdraw a presented request.
REQ-016 In DATA, SHALL keep data_req=0.
- On data_data_ok=1, go to DONE if ext_stall=1, else go to IDLE.
REQ-017 SHALL ignore data_data_ok in any state other than DATA.
REQ-018 In DONE, SHALL issue no request and hold the result; leave for IDLE in the first cycle with ext_stall=0.
REQ-019 SHALL assert mem_stallM whenever a memory op is present, unflushed and aligned, except in the completing cycle (DATA with data_data_ok=1) and in DONE.
REQ-020 SHALL drive data_wr=memwriteM, data_size=memsizeM and data_addr=aluoutM.
REQ-021 SHALL replicate data_wdata: byte gives {4{wd[7:0]}}, half gives {2{wd[15:0]}}, word gives wd.
REQ-022 SHALL form readdataM as follows.
- Select the byte or half of data_rdata by addr[1:0], little-endian, then sign- or zero-extend per loadsignM.
- Drive it combinationally in the completion cycle and from a holding register in DONE.
- Otherwise readdataM holds the last captured value.
REQ-023 SHALL mark a transaction flushed if flushM is seen while in ADDR or DATA.
- It still completes on the bus, but its result is not captured and the FSM returns to IDLE without entering DONE.
- mem_stallM=1 until completion.
REQ-024 SHALL allow at most one outstanding transaction; a back-to-back access is issued from IDLE in the cycle after the previous one leaves DATA or DONE.

Reset
REQ-025 SHALL, on rst=1, asynchronously set the state to IDLE and clear the holding register, the flushed flag and the consumed flag.
REQ-026 SHALL hold all outputs at 0 during reset, except data_addr and data_wdata, which track their inputs.
REQ-027 SHALL, when reset arrives mid-transaction, abandon the transaction and ignore any later data_data_ok until a new request is issued.

Structure
REQ-028 SHALL take the size codes (byte/half/word) and FSM state encodings from the shared CPU defines header, also used by the controller and datapath.
REQ-029 SHALL place load extraction and extension in one combinational sub-module, load_align (inputs rdata, addr[1:0], size, sign; output 32-bit data).

Verification
REQ-030 Word load, addr=0x100, addr_ok in the issue cycle, data_ok one cycle later with rdata=0xDEADBEEF -> readdataM=0xDEADBEEF, and mem_stallM high for exactly 1 cycle.
REQ-031 Signed byte load, addr=0x103, rdata=0x80xxxxxx -> readdataM=0xFFFFFF80; unsigned -> 0x00000080.
REQ-032 Half store, wd=0x1234ABCD, addr=0x202, addr_ok delayed 3 cycles -> data_req high for 4 cycles with stable bus outputs, data_wdata=0xABCDABCD and data_size=01.
REQ-033 Word load at 0x101 -> adelM=1, data_req never asserted, mem_stallM=0; a word store at 0x102 -> adesM=1.
REQ-034 Load completes while ext_stall=1 for 2 more cycles -> FSM in DONE, readdataM held and mem_stallM=0, with no re-issue; return to IDLE when ext_stall drops.
REQ-035 flushM during DATA -> the transaction completes, readdataM is unchanged, the FSM does not enter DONE, and no new request is issued that cycle.
